id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 32-bit MIPS core; sits directly upstream of the ALU and drives its alu_src1, alu_src2 and alu_ctr inputs.
- Captures decoded operands and control from the decode stage, and applies EX/MEM and MEM/WB forwarding to the ALU operands.
- Detects load-use hazards and inserts bubbles; honours external stall and flush.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/fwd_mux.sv | 30 +++
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core datapath: widths, the zero register,
// ALU operation codes and the immediate extender.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_XOR = 3'b010,
        ALU_NOR = 3'b011,
        ALU_SLT = 3'b100,
        ALU_ADD = 3'b101,
        ALU_SUB = 3'b110
    } alu_op_e;

    // andi/ori/xori use a zero-extended immediate, everything else sign-extends
    function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm,
                                                  input logic        zext);
        return zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Two-source operand forwarding select. EX/MEM is the younger producer and
// wins over MEM/WB; register 0 is hard-wired and never forwarded.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0]     reg_val,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic [DATA_W-1:0]     fwd_val
);

    // pick the youngest in-flight producer of src_addr, else the latched operand
    always_comb begin
        fwd_val = reg_val;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_addr)) begin
            fwd_val = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_addr)) begin
            fwd_val = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Latches decoded operands and
// control, forwards EX/MEM and MEM/WB results onto the ALU operands, and
// inserts bubbles on load-use hazards.
// Optional: define BUBBLE_CNT_EN to add a saturating bubble_cnt output that
// counts inserted load-use bubbles.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [15:0]           imm16,
    input  logic                  imm_zext,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [2:0]            alu_ctr_in,
    input  logic                  alu_src_imm,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic [DATA_W-1:0]     alu_src1,
    output logic [DATA_W-1:0]     alu_src2,
    output logic [2:0]            alu_ctr,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  load_use_hazard
`ifdef BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0]      bubble_cnt
`endif
);

    logic                  valid_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  alu_src_imm_q;
    logic [2:0]            alu_ctr_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [REG_ADDR_W-1:0] rs_addr_q;
    logic [REG_ADDR_W-1:0] rt_addr_q;
    logic [DATA_W-1:0]     rs_val_q;
    logic [DATA_W-1:0]     rt_val_q;
    logic [DATA_W-1:0]     imm_q;

    logic [DATA_W-1:0]     rs_cap;
    logic [DATA_W-1:0]     rt_cap;
    logic [DATA_W-1:0]     rs_fwd;
    logic [DATA_W-1:0]     rt_fwd;

    // the register file is written at the end of WB, so a same-cycle MEM/WB
    // write is not yet visible in rs_data/rt_data and must be bypassed here
    always_comb begin
        rs_cap = rs_data;
        rt_cap = rt_data;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr)) begin
            rs_cap = memwb_result;
        end
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_addr)) begin
            rt_cap = memwb_result;
        end
    end

    fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs (
        .src_addr        (rs_addr_q),
        .reg_val         (rs_val_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_val         (rs_fwd)
    );

    fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rt (
        .src_addr        (rt_addr_q),
        .reg_val         (rt_val_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_val         (rt_fwd)
    );

    assign alu_src1     = rs_fwd;
    assign alu_src2     = alu_src_imm_q ? imm_q : rt_fwd;
    assign alu_ctr      = alu_ctr_q;
    assign ex_valid     = valid_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q & valid_q;
    assign ex_mem_read  = mem_read_q & valid_q;

    // a load in EX cannot forward its data yet; rt only matters when it is
    // actually used as operand 2
    assign load_use_hazard = in_valid & ex_mem_read & (rd_q != REG_ZERO) &
                             ((rd_q == rs_addr) | (~alu_src_imm & (rd_q == rt_addr)));

    // pipeline register update: flush > stall > load-use bubble > capture
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            alu_src_imm_q <= 1'b0;
            alu_ctr_q     <= 3'b000;
            rd_q          <= '0;
            rs_addr_q     <= '0;
            rt_addr_q     <= '0;
            rs_val_q      <= '0;
            rt_val_q      <= '0;
            imm_q         <= '0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (stall) begin
            // keep the forwarded values so they survive the producer retiring
            rs_val_q <= rs_fwd;
            rt_val_q <= rt_fwd;
        end else if (load_use_hazard) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q       <= in_valid;
            reg_write_q   <= reg_write_in;
            mem_read_q    <= mem_read_in;
            alu_src_imm_q <= alu_src_imm;
            alu_ctr_q     <= alu_ctr_in;
            rd_q          <= rd_addr;
            rs_addr_q     <= rs_addr;
            rt_addr_q     <= rt_addr;
            rs_val_q      <= rs_cap;
            rt_val_q      <= rt_cap;
            imm_q         <= ext_imm(imm16, imm_zext);
        end
    end

`ifdef BUBBLE_CNT_EN
    logic bubble_take;

    assign bubble_take = load_use_hazard & ~flush & ~stall;

    // saturating count of inserted load-use bubbles
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (bubble_take && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`else
    // without the counter CNT_W only has to be a legal width
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage. Stimulus queues the expected outputs of
// each cycle it drives; the monitor pops and compares them on the falling edge.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm16;
    logic        imm_zext;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [2:0]  alu_ctr_in;
    logic        alu_src_imm, reg_write_in, mem_read_in, stall, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_src1, alu_src2;
    logic [2:0]  alu_ctr;
    logic        ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
    logic [4:0]  ex_rd;
`ifdef BUBBLE_CNT_EN
    logic [1:0]  bubble_cnt;
`endif

    always #5 CLK = ~CLK;

    id_ex_stage #(
        .DATA_W     (32),
        .REG_ADDR_W (5)
`ifdef BUBBLE_CNT_EN
        , .CNT_W    (2)
`endif
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .in_valid        (in_valid),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .imm16           (imm16),
        .imm_zext        (imm_zext),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rd_addr         (rd_addr),
        .alu_ctr_in      (alu_ctr_in),
        .alu_src_imm     (alu_src_imm),
        .reg_write_in    (reg_write_in),
        .mem_read_in     (mem_read_in),
        .stall           (stall),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .alu_src1        (alu_src1),
        .alu_src2        (alu_src2),
        .alu_ctr         (alu_ctr),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .load_use_hazard (load_use_hazard)
`ifdef BUBBLE_CNT_EN
        , .bubble_cnt    (bubble_cnt)
`endif
    );

    typedef struct {
        string       name;
        int          due;
        bit          chk_ops;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [2:0]  ctr;
        logic [4:0]  rd;
        logic        v;
        logic        rw;
        logic        mr;
        logic        hz;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_err   = 0;
    int   exp_bub = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // monitor: compare every expectation due in the current cycle
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due < cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", mon_e.name, mon_e.due, cyc);
            end else begin
                chk({mon_e.name, ".ex_valid"}, 32'(ex_valid), 32'(mon_e.v));
                chk({mon_e.name, ".ex_reg_write"}, 32'(ex_reg_write), 32'(mon_e.rw));
                chk({mon_e.name, ".ex_mem_read"}, 32'(ex_mem_read), 32'(mon_e.mr));
                chk({mon_e.name, ".load_use_hazard"}, 32'(load_use_hazard), 32'(mon_e.hz));
                if (mon_e.chk_ops) begin
                    chk({mon_e.name, ".alu_src1"}, alu_src1, mon_e.s1);
                    chk({mon_e.name, ".alu_src2"}, alu_src2, mon_e.s2);
                    chk({mon_e.name, ".alu_ctr"}, 32'(alu_ctr), 32'(mon_e.ctr));
                    chk({mon_e.name, ".ex_rd"}, 32'(ex_rd), 32'(mon_e.rd));
                end
`ifdef BUBBLE_CNT_EN
                chk({mon_e.name, ".bubble_cnt"}, 32'(bubble_cnt), 32'(mon_e.cnt));
`endif
            end
        end
    end

    task automatic expect_now(input string nm, input bit ops,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [2:0] ctr, input logic [4:0] rd,
                              input logic v, input logic rw, input logic mr, input logic hz);
        exp_t e;
        e.name    = nm;
        e.due     = cyc;
        e.chk_ops = ops;
        e.s1      = s1;
        e.s2      = s2;
        e.ctr     = ctr;
        e.rd      = rd;
        e.v       = v;
        e.rw      = rw;
        e.mr      = mr;
        e.hz      = hz;
        e.cnt     = (exp_bub > 3) ? 3 : exp_bub;
        sb.push_back(e);
    endtask

    task automatic expect_ctl(input string nm, input logic v, input logic rw,
                              input logic mr, input logic hz);
        expect_now(nm, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, v, rw, mr, hz);
    endtask

    task automatic idle();
        in_valid = 0; rs_data = 0; rt_data = 0; imm16 = 0; imm_zext = 0;
        rs_addr = 0; rt_addr = 0; rd_addr = 0; alu_ctr_in = 3'b000;
        alu_src_imm = 0; reg_write_in = 0; mem_read_in = 0; stall = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) tick();
        expect_now("reset", 1'b1, 32'h0, 32'h0, 3'b000, 5'd0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;

        // plain capture
        in_valid = 1; rs_addr = 1; rt_addr = 2; rs_data = 15; rt_data = 5;
        alu_ctr_in = ALU_SUB; rd_addr = 3; reg_write_in = 1;
        expect_ctl("pre_capture", 0, 0, 0, 0);
        tick(); idle();
        expect_now("basic", 1'b1, 32'd15, 32'd5, ALU_SUB, 5'd3, 1, 1, 0, 0);
        tick();

        // EX/MEM beats MEM/WB
        in_valid = 1; rs_addr = 8; rs_data = 32'hAAAA; alu_ctr_in = ALU_ADD; rd_addr = 10; reg_write_in = 1;
        tick(); idle();
        exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h7FFE0000;
        memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'h1;
        expect_now("fwd_exmem", 1'b1, 32'h7FFE0000, 32'h0, ALU_ADD, 5'd10, 1, 1, 0, 0);
        tick(); idle();

        // MEM/WB only
        in_valid = 1; rs_addr = 8; rs_data = 32'hAAAA; alu_ctr_in = ALU_OR; rd_addr = 10; reg_write_in = 1;
        tick(); idle();
        exmem_reg_write = 0; exmem_rd = 8; exmem_result = 32'h7FFE0000;
        memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'h1;
        expect_now("fwd_memwb", 1'b1, 32'h1, 32'h0, ALU_OR, 5'd10, 1, 1, 0, 0);
        tick(); idle();

        // register 0 is never forwarded
        in_valid = 1; alu_ctr_in = ALU_AND; rd_addr = 4; reg_write_in = 1;
        tick(); idle();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h7FFE0000;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'h1;
        expect_now("fwd_r0", 1'b1, 32'h0, 32'h0, ALU_AND, 5'd4, 1, 1, 0, 0);
        tick(); idle();

        // capture-time MEM/WB bypass on rt
        in_valid = 1; rs_addr = 2; rt_addr = 5; rs_data = 32'h10; rt_data = 32'h1;
        alu_ctr_in = ALU_XOR; rd_addr = 6; reg_write_in = 1;
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h77;
        tick(); idle();
        expect_now("wb_bypass", 1'b1, 32'h10, 32'h77, ALU_XOR, 5'd6, 1, 1, 0, 0);
        tick();

        // immediate extension
        in_valid = 1; rs_addr = 1; rs_data = 2; rt_addr = 3; rt_data = 3; imm16 = 16'hFFFB;
        alu_src_imm = 1; imm_zext = 0; alu_ctr_in = ALU_ADD; rd_addr = 3; reg_write_in = 1;
        tick();
        imm_zext = 1;
        expect_now("imm_sext", 1'b1, 32'h2, 32'hFFFFFFFB, ALU_ADD, 5'd3, 1, 1, 0, 0);
        tick(); idle();
        expect_now("imm_zext", 1'b1, 32'h2, 32'h0000FFFB, ALU_ADD, 5'd3, 1, 1, 0, 0);
        tick();

        // load-use on rs: bubble, then capture and forward from MEM/WB
        in_valid = 1; rs_addr = 1; rs_data = 32'h2000; imm16 = 16'h0004; alu_src_imm = 1;
        alu_ctr_in = ALU_ADD; rd_addr = 9; reg_write_in = 1; mem_read_in = 1;
        tick(); idle();
        in_valid = 1; rs_addr = 9; rt_addr = 4; rs_data = 32'hDEAD; rt_data = 32'h4;
        alu_ctr_in = ALU_SUB; rd_addr = 11; reg_write_in = 1;
        expect_now("lu_hold", 1'b1, 32'h2000, 32'h4, ALU_ADD, 5'd9, 1, 1, 1, 1);
        exp_bub++;
        tick();
        exmem_reg_write = 1; exmem_rd = 9; exmem_result = 32'h2004;
        expect_ctl("lu_bubble", 0, 0, 0, 0);
        tick(); idle();
        memwb_reg_write = 1; memwb_rd = 9; memwb_result = 32'hCAFE;
        expect_now("lu_fwd", 1'b1, 32'hCAFE, 32'h4, ALU_SUB, 5'd11, 1, 1, 0, 0);
        tick(); idle();

        // rt only hazards when it is used as operand 2
        in_valid = 1; rs_addr = 1; rd_addr = 9; mem_read_in = 1; reg_write_in = 1; alu_src_imm = 1;
        tick(); idle();
        stall = 1; in_valid = 1; rs_addr = 1; rt_addr = 9; alu_src_imm = 1;
        expect_ctl("lu_rt_imm", 1, 1, 1, 0);
        tick();
        stall = 0; alu_src_imm = 0;
        expect_ctl("lu_rt_reg", 1, 1, 1, 1);
        exp_bub++;
        tick(); idle();
        expect_ctl("lu_rt_bubble", 0, 0, 0, 0);
        tick();

        // load to r0 never hazards
        in_valid = 1; rd_addr = 0; mem_read_in = 1; reg_write_in = 1;
        tick(); idle();
        in_valid = 1;
        expect_ctl("lu_r0", 1, 1, 1, 0);
        tick(); idle();

        // stall while the producer moves EX/MEM -> MEM/WB -> retired, then flush
        in_valid = 1; rs_addr = 7; alu_ctr_in = ALU_OR; rd_addr = 12; reg_write_in = 1;
        tick(); idle();
        stall = 1; exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'h123;
        expect_now("stall0", 1'b1, 32'h123, 32'h0, ALU_OR, 5'd12, 1, 1, 0, 0);
        tick();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'h123;
        expect_now("stall1", 1'b1, 32'h123, 32'h0, ALU_OR, 5'd12, 1, 1, 0, 0);
        tick();
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
        expect_now("stall2", 1'b1, 32'h123, 32'h0, ALU_OR, 5'd12, 1, 1, 0, 0);
        tick();
        flush = 1;
        expect_now("stall_flush", 1'b1, 32'h123, 32'h0, ALU_OR, 5'd12, 1, 1, 0, 0);
        tick(); idle();
        expect_ctl("flushed", 0, 0, 0, 0);
        tick();

        // two more load-use bubbles (four in total)
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; rd_addr = 9; mem_read_in = 1; reg_write_in = 1;
            tick(); idle();
            in_valid = 1; rs_addr = 9;
            expect_ctl($sformatf("bub%0d", k), 1, 1, 1, 1);
            exp_bub++;
            tick(); idle();
            expect_ctl($sformatf("bub%0d_after", k), 0, 0, 0, 0);
            tick();
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: actual=%0d pending expectations required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
